// File: rtl/soc_img_pkg.sv
// Shared image-pipeline definitions.
// Pixel format is packed {R,G,B}, 8 bits per channel, R in the top byte.
package soc_img_pkg;
  localparam int PIX_W = 24;
  localparam int CH_W  = 8;

  // channel slice positions within a pixel word
  localparam int R_LSB = 16;
  localparam int G_LSB = 8;
  localparam int B_LSB = 0;

  // default frame geometry
  localparam int DEF_WIDTH  = 32;
  localparam int DEF_HEIGHT = 32;

  typedef struct packed {
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
  } pix_t;
endpackage

// File: rtl/line_mem.sv
// Single-port line memory, DEPTH x PIX_W.
// Read is combinational at addr, write lands on the rising edge, so a
// read and a write to the same index in one cycle returns the old word.
// Contents are intentionally not reset.
//   clk   : clock
//   we    : write enable
//   addr  : read/write index
//   wdata : word to write
//   rdata : word currently stored at addr
module line_mem
  import soc_img_pkg::*;
#(
  parameter int DEPTH = DEF_WIDTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [PIX_W-1:0] wdata,
  output logic [PIX_W-1:0] rdata
);
  logic [PIX_W-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;
endmodule

// File: rtl/line_buffer_3x3.sv
// 3x3 line buffer: buffers two previous rows of a raster pixel stream and
// presents a 3x3 tap window after each accepted pixel.
//   clk, rstb        : clock, async active-low reset
//   pix_data/valid   : upstream pixel stream, pix_ready is the accept strobe
//   in_data_1..9     : window taps, row-major, 1 = (r-2,c-2), 9 = (r,c)
//   buf_valid        : taps valid, held until win_ready
//   in_row2_cond     : taps form a full in-image window (r>=2, c>=2)
//   win_ready        : downstream consume
//   frame_end        : pulse the cycle after the last frame pixel is taken
module line_buffer_3x3
  import soc_img_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int HEIGHT      = DEF_HEIGHT,
  parameter int KERNEL_SIZE = 3
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic [PIX_W-1:0] pix_data,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic [PIX_W-1:0] in_data_1,
  output logic [PIX_W-1:0] in_data_2,
  output logic [PIX_W-1:0] in_data_3,
  output logic [PIX_W-1:0] in_data_4,
  output logic [PIX_W-1:0] in_data_5,
  output logic [PIX_W-1:0] in_data_6,
  output logic [PIX_W-1:0] in_data_7,
  output logic [PIX_W-1:0] in_data_8,
  output logic [PIX_W-1:0] in_data_9,
  output logic             buf_valid,
  output logic             in_row2_cond,
  input  logic             win_ready,
  output logic             frame_end
);
  localparam int K     = KERNEL_SIZE;
  localparam int NL    = K - 1;            // number of line memories
  localparam int COL_W = $clog2(WIDTH);
  localparam int ROW_W = $clog2(HEIGHT);

  logic             acc;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             col_last, row_last;

  // line 0 holds row r-1, line 1 holds row r-2
  logic [NL-1:0][PIX_W-1:0]       line_rd, line_wr;
  logic [K-1:0][PIX_W-1:0]        new_col;   // [0] = top, [K-1] = bottom
  logic [K-1:0][K-1:0][PIX_W-1:0] taps;      // [row][col], [0][0] = top-left

  // single output register, no skid: downstream consume frees the slot
  assign pix_ready = !buf_valid || win_ready;
  assign acc       = pix_valid && pix_ready;
  assign col_last  = (col == COL_W'(WIDTH - 1));
  assign row_last  = (row == ROW_W'(HEIGHT - 1));

  // line memories cascade: pixel -> line 0 -> line 1, all at index col
  for (genvar i = 0; i < NL; i++) begin : g_line
    if (i == 0) begin : g_first
      assign line_wr[i] = pix_data;
    end else begin : g_next
      assign line_wr[i] = line_rd[i-1];
    end
    line_mem #(.DEPTH(WIDTH), .AW(COL_W)) u_line (
      .clk  (clk),
      .we   (acc),
      .addr (col),
      .wdata(line_wr[i]),
      .rdata(line_rd[i])
    );
  end

  // incoming column, oldest row on top
  for (genvar k = 0; k < K; k++) begin : g_col
    if (k == K - 1) begin : g_bot
      assign new_col[k] = pix_data;
    end else begin : g_mem
      assign new_col[k] = line_rd[K-2-k];
    end
  end

  always_ff @(posedge clk or negedge rstb)
    if (!rstb) begin
      col <= '0;
      row <= '0;
    end else if (acc) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end

  // tap array shifts left, new column enters on the right
  always_ff @(posedge clk or negedge rstb)
    if (!rstb) begin
      taps <= '0;
    end else if (acc) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) taps[r][c] <= taps[r][c+1];
        taps[r][K-1] <= new_col[r];
      end
    end

  always_ff @(posedge clk or negedge rstb)
    if (!rstb) begin
      buf_valid    <= 1'b0;
      in_row2_cond <= 1'b0;
      frame_end    <= 1'b0;
    end else begin
      frame_end <= acc && col_last && row_last;
      if (acc) begin
        buf_valid    <= 1'b1;
        // pre-increment position of the pixel just taken
        in_row2_cond <= (row >= ROW_W'(K - 1)) && (col >= COL_W'(K - 1));
      end else if (win_ready) begin
        buf_valid <= 1'b0;
      end
    end

  assign in_data_1 = taps[0][0];
  assign in_data_2 = taps[0][1];
  assign in_data_3 = taps[0][2];
  assign in_data_4 = taps[1][0];
  assign in_data_5 = taps[1][1];
  assign in_data_6 = taps[1][2];
  assign in_data_7 = taps[2][0];
  assign in_data_8 = taps[2][1];
  assign in_data_9 = taps[2][2];
endmodule
